// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: data width, canonical NOP word and instruction type.
package rv_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] instr_t;

    localparam instr_t NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_word_sel.sv
// Combinational instruction-store lookup: word index decode, range check and word mux.
module imem_word_sel #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] tab_inst [DEPTH],
    output logic [XLEN-1:0] word,
    output logic            in_range
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] w_idx;
    logic             w_unused_byte_ofs;

    // Fetch is word-aligned; the byte offset within the word is dropped.
    assign w_unused_byte_ofs = ^addr[1:0];

    assign w_idx    = addr[IDX_W+1:2];
    assign in_range = (addr[XLEN-1:IDX_W+2] == '0);
    assign word     = tab_inst[w_idx];

endmodule

// File: rtl/fetch_imem.sv
// Instruction-fetch memory stage: registers the word at byte address addr from the ROM image.
module fetch_imem #(
    parameter int               XLEN      = rv_pkg::XLEN,
    parameter int               DEPTH     = 4,
    parameter logic [XLEN-1:0]  NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] tab_inst [DEPTH],
    input  logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] inst_out
);

    logic [XLEN-1:0] w_word;
    logic            w_in_range;
    logic [XLEN-1:0] r_inst;

    imem_word_sel #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_word_sel (
        .addr     (addr),
        .tab_inst (tab_inst),
        .word     (w_word),
        .in_range (w_in_range)
    );

    // Out-of-range fetches return a NOP so decode never sees garbage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst <= NOP_INSTR;
        end else begin
            r_inst <= w_in_range ? w_word : NOP_INSTR;
        end
    end

    assign inst_out = r_inst;

endmodule

// File: tb/tb_fetch_imem.sv
// Scoreboard bench for fetch_imem: directed scenarios plus random fetches against a word-array model.
module tb_fetch_imem;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] tab [DEPTH];
    logic [31:0] inst_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];

    fetch_imem #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tab_inst (tab),
        .addr     (addr),
        .inst_out (inst_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: byte address -> word number; anything past the last word is a NOP.
    function automatic logic [31:0] model(input logic [31:0] a);
        longint unsigned word_no;
        word_no = longint'(a) / 4;
        if (word_no < DEPTH) return tab[int'(word_no)];
        return NOP;
    endfunction

    // One cycle of stimulus: inputs change after the edge, expectation queued for the next edge.
    task automatic cyc(input logic [31:0] a);
        @(posedge clk);
        #3;
        addr = a;
        exp_q.push_back(model(a));
    endtask

    task automatic cyc_tab(input int idx, input logic [31:0] val, input logic [31:0] a);
        @(posedge clk);
        #3;
        tab[idx] = val;
        addr = a;
        exp_q.push_back(model(a));
    endtask

    // Monitor: compare just after each edge, then again mid-cycle after inputs have moved.
    initial begin
        logic [31:0] exp_v;
        bit popped;
        exp_v = '0;
        forever begin
            @(posedge clk);
            #1;
            popped = 1'b0;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                check("fetch", inst_out, exp_v);
                popped = 1'b1;
            end
            #3;
            if (popped) check("hold", inst_out, exp_v);
        end
    end

    initial begin
        int wait_cnt;
        logic [31:0] a;
        rst  = 1'b1;
        addr = 32'h0;
        tab[0] = 32'haaaa_aaaa;
        tab[1] = 32'hbbbb_bbbb;
        tab[2] = 32'hcccc_cccc;
        tab[3] = 32'hdddd_dddd;
        #1;
        rst = 1'b0;
        #1;
        check("reset_async", inst_out, NOP);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", inst_out, NOP);

        @(posedge clk);
        #3;
        rst  = 1'b1;
        addr = 32'h0;
        exp_q.push_back(model(32'h0));

        repeat (9)  cyc(32'h0);
        repeat (10) cyc(32'h4);
        repeat (10) cyc(32'h8);
        repeat (10) cyc(32'hC);
        repeat (3)  cyc(32'h5);
        repeat (3)  cyc(32'h10);
        repeat (3)  cyc(32'h8000_0000);
        repeat (3)  cyc(32'hFFFF_FFFC);
        repeat (3)  cyc(32'h8);
        cyc_tab(2, 32'h1234_5678, 32'h8);
        repeat (3)  cyc(32'h8);
        cyc_tab(2, 32'hcccc_cccc, 32'h8);
        repeat (2)  cyc(32'h8);

        @(posedge clk);
        #6;
        check("pre_reset", inst_out, 32'hcccc_cccc);
        rst = 1'b0;
        #1;
        check("reset_midcycle", inst_out, NOP);
        @(posedge clk);
        #1;
        check("reset_hold_edge", inst_out, NOP);
        #2;
        rst = 1'b1;
        exp_q.push_back(model(addr));

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 4 * DEPTH - 1);
                1: a = $urandom_range(4 * DEPTH - 4, 4 * DEPTH + 7);
                2: a = $urandom();
                default: a = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 27'h0, 4'($urandom_range(0, 15))};
            endcase
            if ($urandom_range(0, 4) == 0)
                cyc_tab($urandom_range(0, DEPTH - 1), $urandom(), a);
            else
                cyc(a);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        #6;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
